// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle triggers into fixed-width level pulses
//
// Purpose: each accepted trigger drives level high for HIGH_CYCLES cycles,
// followed by at least LOW_CYCLES low cycles. One trigger may be queued while
// busy; a further trigger is dropped and flagged on overrun.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   trig     in   trigger request, every high sample is one trigger
//   level    out  stretched output level (registered)
//   busy     out  high whenever the block is not idle (registered)
//   p_edge   out  one-cycle marker on the rise of level (registered)
//   n_edge   out  one-cycle marker on the fall of level (registered)
//   overrun  out  one-cycle pulse when a trigger is dropped (registered)

module pulse_stretcher #(
  parameter int CNT_W       = 16,
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int RETRIGGER   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trig,
  output logic level,
  output logic busy,
  output logic p_edge,
  output logic n_edge,
  output logic overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HIGH_RELOAD = CNT_W'(HIGH_CYCLES - 1);
  // With no gap configured the low reload is never used; keep it at zero
  // instead of letting LOW_CYCLES-1 wrap.
  localparam logic [CNT_W-1:0] LOW_RELOAD  = (LOW_CYCLES > 0) ? CNT_W'(LOW_CYCLES - 1) : '0;
  localparam bit HAS_GAP   = (LOW_CYCLES > 0);
  localparam bit RETRIG_EN = (RETRIGGER != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overrun_d;
  logic             level_d;
  logic             level_q, busy_q, p_edge_q, n_edge_q, overrun_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_RELOAD;
        end
      end

      ST_HIGH: begin
        if (trig && RETRIG_EN) begin
          // Restart the high time, also on the terminal cycle.
          cnt_d = HIGH_RELOAD;
        end else if (cnt_q != '0) begin
          cnt_d     = cnt_q - CNT_W'(1);
          pending_d = pending_q | trig;
          overrun_d = pending_q & trig;
        end else if (HAS_GAP) begin
          state_d   = ST_GAP;
          cnt_d     = LOW_RELOAD;
          pending_d = pending_q | trig;
          overrun_d = pending_q & trig;
        end else if (pending_q || trig) begin
          // No gap: chain straight into the next pulse, level never drops.
          cnt_d     = HIGH_RELOAD;
          pending_d = 1'b0;
          overrun_d = pending_q & trig;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CNT_W'(1);
          pending_d = pending_q | trig;
          overrun_d = pending_q & trig;
        end else if (pending_q || trig) begin
          // The queued trigger wins; a simultaneous new one is dropped.
          state_d   = ST_HIGH;
          cnt_d     = HIGH_RELOAD;
          pending_d = 1'b0;
          overrun_d = pending_q & trig;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    level_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      p_edge_q  <= 1'b0;
      n_edge_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      busy_q    <= (state_d != ST_IDLE);
      // Edge markers compare the next level with the one currently driven.
      p_edge_q  <= level_d & ~level_q;
      n_edge_q  <= ~level_d & level_q;
      overrun_q <= overrun_d;
    end
  end

  assign level   = level_q;
  assign busy    = busy_q;
  assign p_edge  = p_edge_q;
  assign n_edge  = n_edge_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

  localparam int NI = 4;
  // Per-instance configuration: default, retrigger, no gap, minimal widths.
  localparam int P_H[NI] = '{4, 4, 4, 1};
  localparam int P_L[NI] = '{2, 2, 0, 1};
  localparam int P_R[NI] = '{0, 1, 0, 0};

  logic clk;
  logic reset_n;
  logic trig;
  logic [NI-1:0] lv, bs, pe, ne, ov;

  pulse_stretcher #(.CNT_W(16), .HIGH_CYCLES(4), .LOW_CYCLES(2), .RETRIGGER(0)) u_def (
    .clk(clk), .reset_n(reset_n), .trig(trig),
    .level(lv[0]), .busy(bs[0]), .p_edge(pe[0]), .n_edge(ne[0]), .overrun(ov[0]));
  pulse_stretcher #(.CNT_W(16), .HIGH_CYCLES(4), .LOW_CYCLES(2), .RETRIGGER(1)) u_ret (
    .clk(clk), .reset_n(reset_n), .trig(trig),
    .level(lv[1]), .busy(bs[1]), .p_edge(pe[1]), .n_edge(ne[1]), .overrun(ov[1]));
  pulse_stretcher #(.CNT_W(16), .HIGH_CYCLES(4), .LOW_CYCLES(0), .RETRIGGER(0)) u_l0 (
    .clk(clk), .reset_n(reset_n), .trig(trig),
    .level(lv[2]), .busy(bs[2]), .p_edge(pe[2]), .n_edge(ne[2]), .overrun(ov[2]));
  pulse_stretcher #(.CNT_W(8), .HIGH_CYCLES(1), .LOW_CYCLES(1), .RETRIGGER(0)) u_h1 (
    .clk(clk), .reset_n(reset_n), .trig(trig),
    .level(lv[3]), .busy(bs[3]), .p_edge(pe[3]), .n_edge(ne[3]), .overrun(ov[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int edge_no = 0;

  // Reference model: each pulse is described by the edge number of its last
  // high cycle; the decision edge follows LOW_CYCLES edges later.
  bit m_act[NI], m_pend[NI], m_lvl[NI], m_prev[NI], m_ov[NI];
  int m_hl[NI];
  int pe_c[NI], ne_c[NI], ov_c[NI];

  task automatic chk(string tag, int i, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s inst%0d edge %0d: got %0b expected %0b", tag, i, edge_no, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int i, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s inst%0d: got %0d expected %0d", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_act[i] = 0; m_pend[i] = 0; m_lvl[i] = 0; m_prev[i] = 0; m_ov[i] = 0; m_hl[i] = 0;
    end
  endtask

  task automatic model_queue(int i, bit t);
    if (t) begin
      if (m_pend[i]) m_ov[i] = 1;
      else m_pend[i] = 1;
    end
  endtask

  task automatic model_step(int i, bit t);
    int n;
    n = edge_no;
    m_ov[i] = 0;
    m_prev[i] = m_lvl[i];
    if (!m_act[i]) begin
      if (t) begin
        m_act[i] = 1;
        m_hl[i] = n + P_H[i] - 1;
      end
    end else if (n <= m_hl[i]) begin
      if (t && P_R[i] != 0) m_hl[i] = n + P_H[i] - 1;
      else model_queue(i, t);
    end else if (n < m_hl[i] + P_L[i] + 1) begin
      if (t && P_R[i] != 0 && n == m_hl[i] + 1) m_hl[i] = n + P_H[i] - 1;
      else model_queue(i, t);
    end else begin
      if (t && P_R[i] != 0 && P_L[i] == 0) m_hl[i] = n + P_H[i] - 1;
      else if (m_pend[i] || t) begin
        if (m_pend[i] && t) m_ov[i] = 1;
        m_pend[i] = 0;
        m_hl[i] = n + P_H[i] - 1;
      end else m_act[i] = 0;
    end
    m_lvl[i] = m_act[i] && (n <= m_hl[i]);
  endtask

  task automatic check_zero(string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_level"}, i, lv[i], 1'b0);
      chk({tag, "_busy"}, i, bs[i], 1'b0);
      chk({tag, "_pedge"}, i, pe[i], 1'b0);
      chk({tag, "_nedge"}, i, ne[i], 1'b0);
      chk({tag, "_overrun"}, i, ov[i], 1'b0);
    end
  endtask

  task automatic do_edge(bit t);
    @(negedge clk);
    trig = t;
    @(posedge clk);
    edge_no++;
    for (int i = 0; i < NI; i++) model_step(i, t);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("level", i, lv[i], m_lvl[i]);
      chk("busy", i, bs[i], m_act[i]);
      chk("p_edge", i, pe[i], m_lvl[i] && !m_prev[i]);
      chk("n_edge", i, ne[i], !m_lvl[i] && m_prev[i]);
      chk("overrun", i, ov[i], m_ov[i]);
      pe_c[i] += int'(pe[i]);
      ne_c[i] += int'(ne[i]);
      ov_c[i] += int'(ov[i]);
    end
  endtask

  // Asynchronous reset pulse placed between two rising edges.
  task automatic mid_reset();
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  task automatic start_scenario();
    @(posedge clk);
    mid_reset();
    edge_no = 0;
    for (int i = 0; i < NI; i++) begin
      pe_c[i] = 0; ne_c[i] = 0; ov_c[i] = 0;
    end
  endtask

  task automatic run_edges(int from, int to, int t1, int t2, int t3);
    for (int e = from; e <= to; e++) do_edge(e == t1 || e == t2 || e == t3);
  endtask

  initial begin
    reset_n = 1'b0;
    trig = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    #1;
    reset_n = 1'b1;

    // Single trigger at edge 10.
    start_scenario();
    run_edges(1, 25, 10, -1, -1);
    chk_int("single_pedges", 0, pe_c[0], 1);
    chk_int("single_nedges", 0, ne_c[0], 1);
    chk_int("single_overruns", 0, ov_c[0], 0);

    // Queued second trigger.
    start_scenario();
    run_edges(1, 25, 10, 12, -1);
    chk_int("queue_pedges", 0, pe_c[0], 2);
    chk_int("queue_overruns", 0, ov_c[0], 0);

    // Third trigger overruns the queue.
    start_scenario();
    run_edges(1, 28, 10, 12, 13);
    chk_int("ovr_pedges", 0, pe_c[0], 2);
    chk_int("ovr_overruns", 0, ov_c[0], 1);

    // Retrigger extends the high time.
    start_scenario();
    run_edges(1, 25, 10, 13, -1);
    chk_int("retrig_pedges", 1, pe_c[1], 1);
    chk_int("retrig_nedges", 1, ne_c[1], 1);
    chk_int("retrig_overruns", 1, ov_c[1], 0);

    // No gap: back-to-back pulses merge.
    start_scenario();
    run_edges(1, 25, 10, 12, -1);
    chk_int("nogap_pedges", 2, pe_c[2], 1);
    chk_int("nogap_nedges", 2, ne_c[2], 1);

    // Reset in the middle of a pulse.
    start_scenario();
    run_edges(1, 11, 10, -1, -1);
    mid_reset();
    run_edges(12, 28, 15, -1, -1);
    chk_int("rst_pedges", 0, pe_c[0], 2);
    chk_int("rst_nedges", 0, ne_c[0], 1);

    // Randomized traffic with varying density and occasional resets.
    start_scenario();
    for (int blk = 0; blk < 20; blk++) begin
      int dens;
      dens = $urandom_range(5, 80);
      for (int k = 0; k < 100; k++) begin
        do_edge($urandom_range(0, 99) < dens);
        if ($urandom_range(0, 299) == 0) mid_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event pulses back into a level: each accepted trigger drives `level` high for a programmed number of cycles, followed by a guaranteed low gap. It is the inverse of the edge-detector stage, turning debounced edge pulses back into clean, fixed-width levels for LEDs, enables and downstream handshakes. It also emits its own rise and fall markers on `level`. One trigger can be queued while the block is busy; any further trigger is flagged as an overrun.

## Interface
- `CNT_W`, 16, width of the internal cycle counter.
- `HIGH_CYCLES`, 4, cycles `level` stays high per trigger. Must be ≥1 and < 2^CNT_W.
- `LOW_CYCLES`, 2, minimum cycles `level` stays low between pulses. Must be 0 or < 2^CNT_W.
- `RETRIGGER`, 0, trigger handling during HIGH:
  - 0: a trigger during HIGH is queued.
  - 1: a trigger during HIGH restarts the high time.

Ports:
- `clk`  in  1  clock; everything samples on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `trig`  in  1  event request, sampled every rising edge. Level or pulse; each high sample counts as one trigger.
- `level`  out  1  stretched output, registered.
- `busy`  out  1  high whenever state ≠ IDLE, registered.
- `p_edge`  out  1  one-cycle marker on the first cycle `level` is high after being low, registered.
- `n_edge`  out  1  one-cycle marker on the first cycle `level` is low after being high, registered.
- `overrun`  out  1  one-cycle pulse when a trigger is dropped, registered.

## Operation
- States:
  - IDLE: `level`=0.
  - HIGH: `level`=1, counter runs.
  - GAP: `level`=0, counter runs.
- Internal `pending` flag holds at most one queued trigger.
- IDLE + `trig` → HIGH; counter loads HIGH_CYCLES−1.
- HIGH, counter ≠ 0: decrement.
- HIGH, counter = 0:
  - LOW_CYCLES ≥ 1 → GAP; counter loads LOW_CYCLES−1.
  - LOW_CYCLES = 0 and a trigger is pending or arriving → stay in HIGH, reload, clear `pending`. `level` stays high; no `n_edge`/`p_edge`.
  - LOW_CYCLES = 0 otherwise → IDLE.
- `trig` during HIGH:
  - RETRIGGER=1: reload counter to HIGH_CYCLES−1. No pending, no overrun. This includes the terminal cycle.
  - RETRIGGER=0: set `pending`. If `pending` is already set, pulse `overrun` and leave `pending` set.
- `trig` during GAP: set `pending`, or pulse `overrun` if already set.
- GAP, counter = 0:
  - `pending` or `trig` → HIGH with reload; clear `pending`.
  - Otherwise → IDLE.
  - If `pending` and `trig` are both present, the trigger is dropped and `overrun` pulses.
- Counter arithmetic: unsigned, CNT_W bits, never decremented below 0.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: `level`, `busy`, `p_edge`, `n_edge`, `overrun` all 0.
  - State IDLE, `pending`=0, counter=0.
  - Reset mid-pulse drops `level` with no `n_edge`.
  - First trigger is accepted at the first rising edge with `reset_n`=1.
- Latency: `trig` sampled at edge k → `level`=1 and `p_edge`=1 after edge k.
- Pulse width: `level` is high for exactly HIGH_CYCLES cycles (edges k..k+HIGH_CYCLES−1). `n_edge`=1 after edge k+HIGH_CYCLES.
- Gap: `level` is low for at least LOW_CYCLES cycles. Earliest re-rise is after edge k+HIGH_CYCLES+LOW_CYCLES.
- Queued pulse rises at exactly that earliest edge.
- `busy` is high from edge k through the last GAP cycle, then falls together with the return to IDLE.
- `p_edge` and `n_edge` are never high in the same cycle.

## Test plan
- Single trigger, defaults, `trig` at edge 10:
  - `level`=1 after edges 10–13, `p_edge` after 10, `n_edge` after 14.
  - `busy` falls after edge 16.
- Queue, RETRIGGER=0, `trig` at edges 10 and 12:
  - Second pulse high after edges 16–19, `p_edge` after 16.
  - No `overrun`.
- Overrun, RETRIGGER=0, `trig` at edges 10, 12 and 13:
  - `overrun`=1 only after edge 13.
  - Exactly two pulses (rising after 10 and 16).
- Retrigger, RETRIGGER=1, `trig` at edges 10 and 13:
  - `level` high after edges 10–16, `n_edge` after 17.
  - Single `p_edge`, no `pending`.
- LOW_CYCLES=0, RETRIGGER=0, `trig` at edges 10 and 12:
  - `level` high continuously after edges 10–17.
  - One `p_edge` after 10, one `n_edge` after 18.
- Reset mid-pulse: `trig` at edge 10, `reset_n` low between edges 11 and 12:
  - All outputs 0 immediately, no `n_edge`.
  - `trig` at edge 15 gives a clean 4-cycle pulse.
